// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone classic pipelined arbiter in front of one slave.
// Tracks accepted-but-unacknowledged strobes so a master's outstanding acks are
// drained before the slave is handed to the other master.
// Optional macro WB_ARB2_FIXED_PRIO_EN: ties in IDLE always go to m0 and the
// round-robin pointer is not built.
module wb_arb2 #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned MAXOUT = 7   // legal range 1..7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack,
  output logic          m0_stall,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack,
  output logic          m1_stall,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack,
  input  logic          s_stall,
  output logic [1:0]    gnt
);

  localparam int unsigned CW = 3;

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] out_q, out_d;
  logic          cap;
  logic          accept;
`ifndef WB_ARB2_FIXED_PRIO_EN
  logic          rr_q, rr_d;  // 1: m1 was granted last
`endif

  assign gnt      = state_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign cap      = (out_q == CW'(MAXOUT));
  assign accept   = s_stb & ~s_stall;

  // Route the granted master onto the slave port; idle and losing masters are stalled.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_o  = '0;
    m0_stall = 1'b1;
    m1_stall = 1'b1;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    unique case (state_q)
      G0: begin
        // A strobe is only meaningful inside a cycle, so stb is qualified by cyc.
        s_cyc    = m0_cyc | (out_q != '0);
        s_stb    = m0_cyc & m0_stb & ~cap;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_o  = m0_dat_i;
        m0_stall = s_stall | cap;
        m0_ack   = s_ack;
      end
      G1: begin
        s_cyc    = m1_cyc | (out_q != '0);
        s_stb    = m1_cyc & m1_stb & ~cap;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_o  = m1_dat_i;
        m1_stall = s_stall | cap;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

  // Outstanding count, grant decision and release.
  always_comb begin
    out_d   = out_q;
    state_d = state_q;
`ifndef WB_ARB2_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    // A stray ack at zero is forwarded but must not wrap the counter.
    if (accept && !s_ack) begin
      out_d = out_q + CW'(1);
    end else if (!accept && s_ack && (out_q != '0)) begin
      out_d = out_q - CW'(1);
    end

    unique case (state_q)
      IDLE: begin
`ifdef WB_ARB2_FIXED_PRIO_EN
        if (m0_cyc) begin
          state_d = G0;
        end else if (m1_cyc) begin
          state_d = G1;
        end
`else
        if (m0_cyc && (!m1_cyc || rr_q)) begin
          state_d = G0;
          rr_d    = 1'b0;
        end else if (m1_cyc) begin
          state_d = G1;
          rr_d    = 1'b1;
        end
`endif
      end
      G0: if (!m0_cyc && (out_d == '0)) state_d = IDLE;
      G1: if (!m1_cyc && (out_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
`ifndef WB_ARB2_FIXED_PRIO_EN
      rr_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
`ifndef WB_ARB2_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: scoreboard bench for wb_arb2 with a small delayed-ack slave model.
module tb_wb_arb2;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int MAXOUT = 2;
  localparam logic [DW-1:0] INJ_DAT = 16'h5A5A;

  logic          clk;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat_i, m1_dat_i;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack, m0_stall, m1_ack, m1_stall;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic          s_ack, s_stall;
  logic [1:0]    gnt;

  logic          sl_ack = 1'b0;
  logic [DW-1:0] sl_dat = '0;
  logic          inj_ack;
  int            ack_dly;

  typedef struct { int m; logic [DW-1:0] d; } exp_t;
  typedef struct { int due; logic [AW-1:0] adr; } sl_t;

  exp_t exp_q[$];
  sl_t  sq[$];
  int   pend[2];
  int   ack_cnt[2];
  int   checks = 0;
  int   errors = 0;
  int   mod_out = 0;
  int   peak = 0;
  int   ecnt = 0;
  logic acc_n = 1'b0;
  logic [AW-1:0] adr_n = '0;

  assign s_ack   = sl_ack | inj_ack;
  assign s_dat_i = inj_ack ? INJ_DAT : sl_dat;

  wb_arb2 #(.AW(AW), .DW(DW), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_stall(m1_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .s_stall(s_stall), .gnt(gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
    return a ^ 16'hD000;
  endfunction

  // Slave: sample acceptance mid-cycle, ack ack_dly cycles after acceptance.
  always @(negedge clk) begin
    acc_n = rst_n && s_cyc && s_stb && !s_stall;
    adr_n = s_adr;
  end

  always @(posedge clk) begin
    ecnt = ecnt + 1;
    if (!rst_n) begin
      sq.delete();
    end else begin
      if (sl_ack && sq.size() != 0) void'(sq.pop_front());
      if (acc_n && ack_dly != 0) sq.push_back('{ecnt + ack_dly, adr_n});
    end
    #2;
    if (sq.size() != 0 && sq[0].due == ecnt + 1) begin
      sl_ack = 1'b1;
      sl_dat = rdata(sq[0].adr);
    end else begin
      sl_ack = 1'b0;
    end
  end

  // Scoreboard and independent outstanding-count model.
  always @(negedge clk) begin
    int mi;
    logic acc;
    exp_t e;
    if (!rst_n) begin
      mod_out = 0;
    end else begin
      acc = s_cyc && s_stb && !s_stall;
      if (mod_out == MAXOUT) begin
        checks++;
        if (s_stb !== 1'b0) begin
          errors++;
          $display("FAIL cap_stb got s_stb=%b exp 0 at outstanding=%0d", s_stb, mod_out);
        end
      end
      if (m0_ack && m1_ack) begin
        checks++;
        errors++;
        $display("FAIL dual_ack got m0_ack=1 m1_ack=1 exp at most one");
      end else if (m0_ack || m1_ack) begin
        mi = m1_ack ? 1 : 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack got ack on m%0d exp none pending", mi);
        end else begin
          e = exp_q.pop_front();
          if (e.m != mi || (mi == 0 ? m0_dat_o : m1_dat_o) !== e.d) begin
            errors++;
            $display("FAIL ack_route got m%0d dat=%h exp m%0d dat=%h", mi,
                     (mi == 0 ? m0_dat_o : m1_dat_o), e.m, e.d);
          end
          pend[e.m]--;
          ack_cnt[mi]++;
        end
      end
      if (acc && !s_ack) mod_out++;
      else if (!acc && s_ack && mod_out > 0) mod_out--;
      if (mod_out > peak) peak = mod_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat_i = dat;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat_i = dat;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    inj_ack = 1'b0;
    s_stall = 1'b0;
    exp_q.delete();
    pend[0] = 0; pend[1] = 0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present one strobe (called right after an edge); returns right after its accepting edge.
  task automatic m_op(input int m, input logic we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] dat);
    int n = 0;
    logic stl = 1'b1;
    set_m(m, 1, 1, we, adr, dat);
    while (stl && n < 100) begin
      @(negedge clk);
      stl = (m == 0) ? m0_stall : m1_stall;
      n++;
    end
    checks++;
    if (stl) begin
      errors++;
      $display("FAIL accept_timeout m%0d got stall=1 exp 0", m);
    end else begin
      exp_q.push_back('{m, rdata(adr)});
      pend[m]++;
    end
    tick();
  endtask

  task automatic wait_acks(input int m);
    int n = 0;
    while (pend[m] != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pend[m] != 0) begin
      errors++;
      $display("FAIL ack_timeout m%0d got pending=%0d exp 0", m, pend[m]);
    end
  endtask

  task automatic burst(input int m, input logic [AW-1:0] base);
    tick();
    set_m(m, 1, 0, 0, base, '0);
    for (int i = 0; i < 3; i++) begin
      m_op(m, 1'b0, AW'(base + AW'(i)), '0);
      set_m(m, 1, 0, 0, base, '0);
      wait_acks(m);
      tick();
    end
    set_m(m, 0, 0, 0, base, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inj_ack = 1'b0;
    s_stall = 1'b0;
    set_m(0, 1, 0, 0, '0, '0);
    set_m(1, 1, 0, 0, '0, '0);
    repeat (2) tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    checks++; if (m0_stall !== 1'b1 || m1_stall !== 1'b1) begin
      errors++; $display("FAIL reset_stall got %b%b exp 11", m0_stall, m1_stall); end
    checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      errors++; $display("FAIL reset_slave got cyc=%b stb=%b exp 0 0", s_cyc, s_stb); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL reset_ack got %b%b exp 00", m0_ack, m1_ack); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_hold_gnt got %b exp 00", gnt); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL first_tie_gnt got %b exp 01", gnt); end
    tick();
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    tick();
  endtask

  task automatic test_tie();
    logic [1:0] seq[$];
    logic [1:0] prev;
    logic [1:0] exp_seq[6];
`ifdef WB_ARB2_FIXED_PRIO_EN
    exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
`else
    exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
`endif
    do_reset();
    ack_dly = 1;
    prev = 2'b00;
    fork
      begin
        burst(0, 16'h0100);
        burst(0, 16'h0110);
      end
      burst(1, 16'h0200);
      begin
        for (int c = 0; c < 300 && seq.size() < 6; c++) begin
          @(negedge clk);
          if (gnt !== prev) begin
            seq.push_back(gnt);
            prev = gnt;
          end
        end
      end
    join
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= seq.size()) begin
        errors++; $display("FAIL tie_seq[%0d] got none exp %b", i, exp_seq[i]);
      end else if (seq[i] !== exp_seq[i]) begin
        errors++; $display("FAIL tie_seq[%0d] got %b exp %b", i, seq[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_burst();
    int n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    do_reset();
    ack_dly = 2;
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      a = AW'(16'h0010 + i);
      d = DW'(16'hA000 + i);
      set_m(0, 1, 1, 1, a, d);
      n = 0;
      do begin @(negedge clk); n++; end while (m0_stall && n < 50);
      checks++;
      if (m0_stall || s_stb !== 1'b1 || s_we !== 1'b1 || s_adr !== a || s_dat_o !== d) begin
        errors++;
        $display("FAIL burst_wr[%0d] got stb=%b we=%b adr=%h dat=%h exp 1 1 %h %h",
                 i, s_stb, s_we, s_adr, s_dat_o, a, d);
      end else begin
        exp_q.push_back('{0, rdata(a)});
        pend[0]++;
      end
      tick();
    end
    set_m(0, 1, 0, 1, a, d);
    wait_acks(0);
    tick();
    set_m(0, 0, 0, 0, '0, '0);
    repeat (3) tick();
    checks++; if (ack_cnt[0] != 4) begin errors++; $display("FAIL burst_m0_acks got %0d exp 4", ack_cnt[0]); end
    checks++; if (ack_cnt[1] != 0) begin errors++; $display("FAIL burst_m1_acks got %0d exp 0", ack_cnt[1]); end
    checks++; if (peak != 2) begin errors++; $display("FAIL burst_peak got %0d exp 2", peak); end
  endtask

  task automatic test_cap();
    int n_acc = 0;
    do_reset();
    ack_dly = 0;
    set_m(1, 1, 1, 0, 16'h0020, '0);
    repeat (8) begin
      @(negedge clk);
      if (s_cyc && s_stb && !s_stall) n_acc++;
    end
    checks++; if (n_acc != 2) begin errors++; $display("FAIL cap_accepts got %0d exp 2", n_acc); end
    checks++; if (m1_stall !== 1'b1 || s_stb !== 1'b0 || s_cyc !== 1'b1) begin
      errors++; $display("FAIL cap_state got stall=%b stb=%b cyc=%b exp 1 0 1", m1_stall, s_stb, s_cyc); end
    tick();
    rst_n = 1'b0;
    set_m(1, 0, 0, 0, '0, '0);
    tick();
    rst_n = 1'b1;
    inj_ack = 1'b1;
    @(negedge clk);
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || gnt !== 2'b00) begin
      errors++; $display("FAIL post_reset_ack got acks=%b%b gnt=%b exp 00 00", m0_ack, m1_ack, gnt); end
    tick();
    inj_ack = 1'b0;
  endtask

  task automatic test_drain();
    int la = -1;
    int ii = -1;
    int ig = -1;
    do_reset();
    ack_dly = 3;
    for (int i = 0; i < 2; i++) m_op(0, 1'b1, AW'(16'h0030 + i), DW'(16'hB000 + i));
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 1, 0, 0, 16'h0240, '0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m0_ack) la = c;
      if (gnt === 2'b00 && ii < 0) ii = c;
      if (gnt === 2'b10 && ig < 0) ig = c;
      if (gnt === 2'b01) begin
        checks++;
        if (s_cyc !== 1'b1 || s_stb !== 1'b0) begin
          errors++; $display("FAIL drain_hold[%0d] got cyc=%b stb=%b exp 1 0", c, s_cyc, s_stb);
        end
      end
    end
    checks++; if (la < 0 || ii != la + 1) begin errors++; $display("FAIL drain_idle got idle@%0d exp last_ack@%0d+1", ii, la); end
    checks++; if (ig != ii + 1) begin errors++; $display("FAIL drain_g1 got g1@%0d exp %0d", ig, ii + 1); end
    checks++; if (pend[0] != 0) begin errors++; $display("FAIL drain_pend got %0d exp 0", pend[0]); end
  endtask

  task automatic test_stray();
    tick();
    inj_ack = 1'b1;
    exp_q.push_back('{1, INJ_DAT});
    pend[1]++;
    @(negedge clk);
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      errors++; $display("FAIL stray_route got m0=%b m1=%b exp 0 1", m0_ack, m1_ack); end
    tick();
    inj_ack = 1'b0;
    set_m(1, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++; if (m1_ack !== 1'b0 || gnt !== 2'b10) begin
      errors++; $display("FAIL stray_pulse got ack=%b gnt=%b exp 0 10", m1_ack, gnt); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL stray_release got gnt=%b exp 00", gnt); end
    checks++; if (mod_out != 0) begin errors++; $display("FAIL stray_count got %0d exp 0", mod_out); end
  endtask

  initial begin
    rst_n = 1'b0;
    inj_ack = 1'b0;
    s_stall = 1'b0;
    ack_dly = 1;
    pend[0] = 0; pend[1] = 0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    test_reset();
    test_tie();
    test_burst();
    test_cap();
    test_drain();
    test_stray();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_expected got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 SHALL have parameter AW, default 16, meaning address width.
REQ-002 SHALL have parameter DW, default 16, meaning data width.
REQ-003 SHALL have parameter MAXOUT, default 7, meaning the maximum number of accepted-but-unacknowledged strobes (1..7).
REQ-004 Port list SHALL be:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe and write enable.
- m0_adr  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_dat_o  out  DW  read data to master 0.
- m0_ack, m0_stall  out  1 each  acknowledge and stall to master 0.
- m1_*  (same ports as m0_*)  master 1.
- s_cyc, s_stb, s_we  out  1 each  slave cycle, strobe and write enable.
- s_adr  out  AW  slave address.
- s_dat_o  out  DW  write data to the slave.
- s_dat_i  in  DW  read data from the slave.
- s_ack, s_stall  in  1 each  slave acknowledge and stall.
- gnt  out  2  one-hot current grant; 00 when idle.

Function
REQ-005 SHALL implement a Wishbone classic pipelined arbiter that shares one slave (single-port RAM) between two masters.
REQ-006 FSM SHALL have three states: IDLE, G0, G1; gnt SHALL be 00, 01 and 10 respectively.
REQ-007 In IDLE:
- A request is m_cyc=1.
- Only m0 requesting -> G0 next cycle; only m1 requesting -> G1 next cycle.
- Both requesting -> grant the master that was not granted last (round-robin pointer).
- Neither requesting -> stay in IDLE.
REQ-008 In IDLE: s_cyc=0, s_stb=0, both m_stall=1, both m_ack=0.
REQ-009 In Gn:
- s_cyc = mn_cyc OR (outstanding≠0).
- s_stb = mn_stb AND NOT cap.
- s_we, s_adr and s_dat_o SHALL be taken from master n.
- mn_stall = s_stall OR cap.
- mn_ack = s_ack.
REQ-010 In Gn, the non-granted master SHALL see stall=1 and ack=0, and its inputs SHALL be ignored.
REQ-011 m0_dat_o and m1_dat_o SHALL both equal s_dat_i at all times.
REQ-012 Outstanding counter: 3-bit, reset 0.
- +1 on each accepted strobe (s_stb AND NOT s_stall).
- -1 on each s_ack.
- Simultaneous accept and ack -> unchanged.
- cap = (outstanding == MAXOUT).
REQ-013 A stray s_ack with outstanding=0 SHALL be forwarded to the granted master, and the counter SHALL stay at 0 (no underflow wrap).
REQ-014 Release: in Gn, when mn_cyc=0 and outstanding=0 (counting any ack in that cycle), the FSM SHALL go to IDLE on the next edge.
REQ-015 After mn_cyc drops with outstanding>0, s_cyc SHALL stay 1, s_stb SHALL be 0, and acks SHALL still be routed to master n until the counter reaches 0.
REQ-016 Every release SHALL pass through IDLE for exactly one cycle, so back-to-back grants are separated by a single dead cycle.
REQ-017 The round-robin pointer SHALL update to n on entry to Gn.
REQ-018 Grant latency SHALL be 1 cycle: a request sampled in IDLE yields a grant and an accepting slave path on the next cycle.
REQ-019 All outputs other than the registered state SHALL be combinational functions of the state, the counter and the inputs.

Reset
REQ-020 While rst_n=0 at a clock edge, the block SHALL return to IDLE, outstanding SHALL be 0, and the pointer SHALL be set so that m0 wins the first tie.
REQ-021 After reset: s_cyc=0, s_stb=0, m0_ack=m1_ack=0, m0_stall=m1_stall=1, gnt=00.
REQ-022 A reset asserted mid-burst SHALL abandon in-flight transactions; subsequent s_ack pulses SHALL be forwarded to no master.

Configuration
REQ-023 Macro WB_ARB2_FIXED_PRIO_EN:
- Defined -> ties in IDLE SHALL always grant m0, and the pointer logic SHALL be removed.
- Undefined -> round-robin per REQ-007 and REQ-017.

Verification
REQ-024 Reset: drive rst_n=0 for 2 cycles with both m_cyc=1 -> gnt=00, both stall=1, s_cyc=0; first tie after release -> gnt=01.
REQ-025 Tie:
- m0 and m1 each hold cyc for 3 single reads; slave acks 1 cycle after strobe.
- Without the macro -> gnt sequence 01, 00, 10, 00, 01.
- With the macro -> 01, 00, 01 for as long as m0 requests.
REQ-026 Pipelined burst:
- m0 issues 4 writes (adr 0x010..0x013, data 0xA000..0xA003) with s_stall=0 and acks delayed 2 cycles.
- Required: 4 acks to m0, none to m1, and outstanding peaks at 2.
REQ-027 Cap: MAXOUT=2, slave never acks; m1 strobes continuously -> exactly 2 strobes accepted, then m1_stall=1 and s_stb=0.
REQ-028 Drain:
- m0 drops cyc with outstanding=2 -> s_cyc stays 1 until both acks arrive.
- IDLE follows on the cycle after the last ack.
- A pending m1 request is granted one cycle after that.
REQ-029 Stray ack: inject s_ack in G1 with outstanding=0 -> m1_ack=1 for 1 cycle and the counter stays 0.
